// File: rtl/id_fwd_scoreboard.sv
// Decode-stage register hazard unit.
// Tracks in-flight writes per register, picks the youngest forwarding source for each operand,
// and stalls decode when an operand cannot be obtained yet.
module id_fwd_scoreboard #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         rs1_addr,
  input  logic [AW-1:0]         rs2_addr,
  input  logic                  rs1_need,
  input  logic                  rs2_need,
  input  logic [DW-1:0]         rf_rdata1,
  input  logic [DW-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [NUM_FWD*AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*DW-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]    fwd_ok,
  input  logic                  issue_fire,
  input  logic                  issue_we,
  input  logic [AW-1:0]         issue_waddr,
  input  logic                  retire_fire,
  input  logic [AW-1:0]         retire_waddr,
  input  logic                  flush,
  output logic [DW-1:0]         rs1_value,
  output logic [DW-1:0]         rs2_value,
  output logic                  stall,
  output logic                  sb_err,
  output logic [31:0]           stall_cycles
);

  localparam int unsigned NREG = 1 << AW;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_set;
  logic             inc_en;
  logic             dec_en;
  logic             rs1_blk;
  logic             rs2_blk;
  logic             issue_full;

  // Returns {blocked, value}. The youngest matching stage decides; a pending result there hides
  // any older stage, since older data would be stale.
  function automatic logic [DW:0] resolve(
    input logic [AW-1:0]         addr,
    input logic [DW-1:0]         rf,
    input logic [CNT_W-1:0]      cnt,
    input logic [NUM_FWD-1:0]    we,
    input logic [NUM_FWD*AW-1:0] waddr,
    input logic [NUM_FWD*DW-1:0] wdata,
    input logic [NUM_FWD-1:0]    ok
  );
    logic          hit;
    logic          blk;
    logic [DW-1:0] val;
    hit = 1'b0;
    blk = 1'b0;
    val = rf;
    if (addr == '0) begin
      val = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && we[i] && (waddr[i*AW +: AW] == addr)) begin
          hit = 1'b1;
          blk = ~ok[i];
          if (ok[i]) val = wdata[i*DW +: DW];
        end
      end
      // Multi-cycle producers never appear on a forward path; only the counter reveals them.
      if (!hit && (cnt != '0)) blk = 1'b1;
    end
    return {blk, val};
  endfunction

  // Operand resolution and stall generation.
  always_comb begin
    {rs1_blk, rs1_value} = resolve(rs1_addr, rf_rdata1, cnt_q[rs1_addr],
                                   fwd_we, fwd_waddr, fwd_wdata, fwd_ok);
    {rs2_blk, rs2_value} = resolve(rs2_addr, rf_rdata2, cnt_q[rs2_addr],
                                   fwd_we, fwd_waddr, fwd_wdata, fwd_ok);
    issue_full = issue_we && (issue_waddr != '0) && (cnt_q[issue_waddr] == CntMax);
    stall = (rs1_need && rs1_blk) || (rs2_need && rs2_blk) || issue_full;
  end

  // Next-state of the pending-write counters.
  always_comb begin
    cnt_d   = cnt_q;
    err_set = 1'b0;
    inc_en  = issue_fire && issue_we && (issue_waddr != '0);
    dec_en  = retire_fire && (retire_waddr != '0);
    if (flush) begin
      for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
    end else if (!(inc_en && dec_en && (issue_waddr == retire_waddr))) begin
      // Saturate rather than wrap: a wrapped counter would silently drop a hazard.
      if (inc_en && (cnt_q[issue_waddr] != CntMax)) begin
        cnt_d[issue_waddr] = cnt_q[issue_waddr] + 1'b1;
      end
      if (dec_en) begin
        if (cnt_q[retire_waddr] != '0) cnt_d[retire_waddr] = cnt_q[retire_waddr] - 1'b1;
        else err_set = 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Sticky error flag and saturating stall counter; flush leaves both alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (err_set) sb_err <= 1'b1;
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Self-checking bench for id_fwd_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register in-flight count model.
module tb_id_fwd_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 3;
  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     rs1_addr, rs2_addr;
  logic              rs1_need, rs2_need;
  logic [DW-1:0]     rf_rdata1, rf_rdata2;
  logic [NF-1:0]     fwd_we, fwd_ok;
  logic [NF*AW-1:0]  fwd_waddr;
  logic [NF*DW-1:0]  fwd_wdata;
  logic              issue_fire, issue_we, retire_fire, flush;
  logic [AW-1:0]     issue_waddr, retire_waddr;
  logic [DW-1:0]     rs1_value, rs2_value;
  logic              stall, sb_err;
  logic [31:0]       stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int          m_cnt [1 << AW];
  bit          m_err;
  logic [31:0] m_sc;
  logic [DW-1:0] e_v1, e_v2;
  bit          e_b1, e_b2, e_stall;

  id_fwd_scoreboard #(.DW(DW), .AW(AW), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_need(rs1_need), .rs2_need(rs2_need),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_ok(fwd_ok),
    .issue_fire(issue_fire), .issue_we(issue_we), .issue_waddr(issue_waddr),
    .retire_fire(retire_fire), .retire_waddr(retire_waddr), .flush(flush),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .stall(stall), .sb_err(sb_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Operand rule: r0 reads zero; otherwise the youngest stage naming the register decides,
  // else any outstanding write means the regfile copy is stale.
  function automatic void ref_op(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                                 output logic [DW-1:0] v, output bit blk);
    v = rf;
    blk = 1'b0;
    if (a == 0) begin
      v = '0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      if (fwd_we[i] && fwd_waddr[i*AW +: AW] == a) begin
        if (fwd_ok[i]) v = fwd_wdata[i*DW +: DW];
        else blk = 1'b1;
        return;
      end
    end
    blk = (m_cnt[a] > 0);
  endfunction

  task automatic model_eval();
    ref_op(rs1_addr, rf_rdata1, e_v1, e_b1);
    ref_op(rs2_addr, rf_rdata2, e_v2, e_b2);
    e_stall = (rs1_need && e_b1) || (rs2_need && e_b2) ||
              (issue_we && issue_waddr != 0 && m_cnt[issue_waddr] == MAXC);
  endtask

  // Advance one clock, applying the inputs present before the edge to the model.
  task automatic tick();
    bit inc, dec;
    model_eval();
    @(posedge clk);
    if (reset) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_err = 1'b0;
      m_sc  = '0;
    end else begin
      if (e_stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (flush) begin
        foreach (m_cnt[r]) m_cnt[r] = 0;
      end else begin
        inc = issue_fire && issue_we && issue_waddr != 0;
        dec = retire_fire && retire_waddr != 0;
        if (!(inc && dec && issue_waddr == retire_waddr)) begin
          if (inc && m_cnt[issue_waddr] < MAXC) m_cnt[issue_waddr]++;
          if (dec) begin
            if (m_cnt[retire_waddr] > 0) m_cnt[retire_waddr]--;
            else m_err = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; rs1_addr = 0; rs2_addr = 0; rs1_need = 0; rs2_need = 0;
    rf_rdata1 = 0; rf_rdata2 = 0; fwd_we = 0; fwd_ok = 0; fwd_waddr = 0; fwd_wdata = 0;
    issue_fire = 0; issue_we = 0; issue_waddr = 0; retire_fire = 0; retire_waddr = 0;
    flush = 0;
  endtask

  task automatic set_fwd(input int i, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit ok);
    fwd_we[i] = we;
    fwd_waddr[i*AW +: AW] = a;
    fwd_wdata[i*DW +: DW] = d;
    fwd_ok[i] = ok;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    issue_fire = 1; issue_we = 1; issue_waddr = a;
    tick();
    issue_fire = 0; issue_we = 0; issue_waddr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; issue_fire = 1; issue_we = 1; issue_waddr = 5;
    tick();
    tick();
    idle_inputs();
    rs1_addr = 5; rs1_need = 1; rf_rdata1 = 32'h11;
    #2;
    n_cmp++; if (rs1_value !== 32'h11) begin n_bad++;
      $display("FAIL reset_rs1 got %h exp %h", rs1_value, 32'h11); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_cmp++; if (sb_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", sb_err); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++;
      $display("FAIL reset_scnt got %0d exp 0", stall_cycles); end
    tick();
  endtask

  task automatic test_youngest();
    idle_inputs();
    issue(7);
    set_fwd(0, 1, 7, 32'hAA, 1);
    set_fwd(2, 1, 7, 32'hBB, 1);
    rs1_addr = 7; rs1_need = 1; rf_rdata1 = 32'h77;
    #2;
    n_cmp++; if (rs1_value !== 32'hAA) begin n_bad++;
      $display("FAIL youngest_val got %h exp %h", rs1_value, 32'hAA); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL youngest_stall got %b exp 0", stall); end
    tick();
  endtask

  task automatic test_load();
    set_fwd(0, 1, 7, 32'hC0, 0);
    set_fwd(1, 1, 7, 32'hC1, 1);
    set_fwd(2, 0, 0, 0, 0);
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_pending got %b exp 1", stall); end
    tick();
    set_fwd(0, 1, 7, 32'hC0, 1);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL load_done got %b exp 0", stall); end
    n_cmp++; if (rs1_value !== 32'hC0) begin n_bad++;
      $display("FAIL load_val got %h exp %h", rs1_value, 32'hC0); end
    retire_fire = 1; retire_waddr = 7;
    tick();
    idle_inputs();
  endtask

  task automatic test_multicycle();
    issue(9);
    rs2_addr = 9; rs2_need = 1; rf_rdata2 = 32'h99;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_cmp++; if (stall !== 1'b1) begin n_bad++;
        $display("FAIL div_wait%0d got %b exp 1", k, stall); end
      tick();
    end
    retire_fire = 1; retire_waddr = 9;
    tick();
    retire_fire = 0;
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL div_done got %b exp 0", stall); end
    n_cmp++; if (rs2_value !== 32'h99) begin n_bad++;
      $display("FAIL div_val got %h exp %h", rs2_value, 32'h99); end
    tick();
    idle_inputs();
  endtask

  task automatic test_count_full();
    issue(3); issue(3); issue(3);
    issue_we = 1; issue_waddr = 3;
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL full_stall got %b exp 1", stall); end
    // Issue and retire of the same register cancel out.
    issue_fire = 1; retire_fire = 1; retire_waddr = 3;
    tick();
    issue_fire = 0; retire_fire = 0;
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL full_cancel got %b exp 1", stall); end
    issue_we = 0;
    retire_fire = 1; retire_waddr = 3;
    tick();
    retire_fire = 0;
    issue_we = 1; issue_waddr = 3;
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL full_below got %b exp 0", stall); end
    idle_inputs();
  endtask

  task automatic test_err_flush();
    retire_fire = 1; retire_waddr = 4;
    tick();
    retire_fire = 0;
    #2;
    n_cmp++; if (sb_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b exp 1", sb_err); end
    // r3 holds 2 in-flight writes here.
    flush = 1; issue_fire = 1; issue_we = 1; issue_waddr = 3;
    tick();
    idle_inputs();
    rs1_addr = 3; rs1_need = 1; rf_rdata1 = 32'h33;
    #2;
    n_cmp++; if (stall !== 1'b0 || rs1_value !== 32'h33) begin n_bad++;
      $display("FAIL flush_clear got stall=%b val=%h exp stall=0 val=33", stall, rs1_value); end
    n_cmp++; if (sb_err !== 1'b1) begin n_bad++; $display("FAIL flush_keep_err got %b exp 1", sb_err); end
    rs1_addr = 0; rf_rdata1 = 32'hDEAD; set_fwd(0, 1, 0, 32'h1234, 0);
    #2;
    n_cmp++; if (rs1_value !== 32'h0 || stall !== 1'b0) begin n_bad++;
      $display("FAIL r0 got val=%h stall=%b exp val=0 stall=0", rs1_value, stall); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    int r;
    reset = 1;
    tick();
    reset = 0;
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      reset = ($urandom_range(0, 79) == 0);
      rs1_addr = AW'($urandom_range(0, 7)); rs2_addr = AW'($urandom_range(0, 7));
      rs1_need = 1'($urandom); rs2_need = 1'($urandom);
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      for (int i = 0; i < NF; i++)
        set_fwd(i, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 3) != 0));
      issue_we = 1'($urandom); issue_waddr = AW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 39) == 0);
      r = $urandom_range(1, 7);
      if (m_cnt[r] > 0 && $urandom_range(0, 2) == 0) begin
        retire_fire = 1; retire_waddr = AW'(r);
      end
      model_eval();
      issue_fire = !e_stall && ($urandom_range(0, 1) == 1);
      #2;
      n_cmp++; if (stall !== e_stall) begin n_bad++;
        $display("FAIL rnd_stall@%0d got %b exp %b", n, stall, e_stall); end
      if (!e_b1) begin
        n_cmp++; if (rs1_value !== e_v1) begin n_bad++;
          $display("FAIL rnd_rs1@%0d got %h exp %h", n, rs1_value, e_v1); end
      end
      if (!e_b2) begin
        n_cmp++; if (rs2_value !== e_v2) begin n_bad++;
          $display("FAIL rnd_rs2@%0d got %h exp %h", n, rs2_value, e_v2); end
      end
      n_cmp++; if (sb_err !== m_err || stall_cycles !== m_sc) begin n_bad++;
        $display("FAIL rnd_stat@%0d got err=%b cyc=%0d exp err=%b cyc=%0d",
                 n, sb_err, stall_cycles, m_err, m_sc); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_err = 0;
    m_sc = 0;
    idle_inputs();
    #1;
    test_reset();
    test_youngest();
    test_load();
    test_multicycle();
    test_count_full();
    test_err_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
